// File: rtl/div_if.sv
// Request/result bundle between the ALU (master) and the radix-2 divider (slave).
interface div_if;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div_radix2.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle, signed or unsigned.
// Result is {remainder, quotient}; ready is registered and only ever high while in END.
module div_radix2 (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [31:0] dvd_reg;      // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_reg;
    logic [31:0] dvsr_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [63:0] result_reg;
    logic        ready_reg;

    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;
    logic        no_borrow;
    logic [31:0] rem_step, dvd_step;
    logic [31:0] quo_fix, rem_fix;

    // Magnitudes of the live operands; only consumed on the latch cycle.
    assign a_mag = (bus.signed_div && bus.opdata1[31]) ? -bus.opdata1 : bus.opdata1;
    assign b_mag = (bus.signed_div && bus.opdata2[31]) ? -bus.opdata2 : bus.opdata2;

    // One restoring step. A successful trial subtract leaves a value below the
    // divisor, so the low 32 bits of the difference are exact.
    assign shifted   = {rem_reg, dvd_reg[31]};
    assign no_borrow = (shifted >= {1'b0, dvsr_reg});
    assign rem_step  = no_borrow ? (shifted[31:0] - dvsr_reg) : shifted[31:0];
    assign dvd_step  = {dvd_reg[30:0], no_borrow};

    assign quo_fix = neg_q_reg ? -dvd_step : dvd_step;
    assign rem_fix = neg_r_reg ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.annul) begin
                    state_next = (bus.opdata2 == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_next = bus.annul ? IDLE : END;
            end
            ON: begin
                // Dropping start mid-divide is an abort, same as annul.
                if (bus.annul || !bus.start) begin
                    state_next = IDLE;
                end else if (cnt_reg == 6'd31) begin
                    state_next = END;
                end
            end
            END: begin
                if (bus.annul || !bus.start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= 6'd0;
            dvd_reg    <= 32'd0;
            rem_reg    <= 32'd0;
            dvsr_reg   <= 32'd0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= 64'h0;
            ready_reg  <= 1'b0;
        end else begin
            // ready lags entry to END by one cycle and drops with the exit edge.
            ready_reg <= (state_reg == END) && (state_next == END);
            case (state_reg)
                IDLE: begin
                    if (state_next != IDLE) begin
                        dvd_reg   <= a_mag;
                        dvsr_reg  <= b_mag;
                        rem_reg   <= 32'd0;
                        cnt_reg   <= 6'd0;
                        neg_q_reg <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
                        neg_r_reg <= bus.signed_div && bus.opdata1[31];
                    end
                end
                BYZERO: begin
                    if (state_next == END) begin
                        result_reg <= 64'h0;
                    end
                end
                ON: begin
                    if (state_next == IDLE) begin
                        cnt_reg <= 6'd0;
                    end else begin
                        dvd_reg <= dvd_step;
                        rem_reg <= rem_step;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (state_next == END) begin
                            result_reg <= {rem_fix, quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.ready  = ready_reg;
endmodule

// File: tb/tb_div_radix2.sv
// Directed and random checks of div_radix2 against an arithmetic model of
// truncating division with the remainder taking the dividend's sign.
module tb_div_radix2;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    div_if bus ();

    div_radix2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called #1 after an edge with the DUT idle: start is sampled at the next edge.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input bit scramble, input string tag);
        logic [63:0] exp;
        int lat;
        int want;
        exp  = model(a, b, s);
        want = (b == 32'd0) ? 2 : 33;
        bus.signed_div = s;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            if (scramble) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (bus.ready) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(want));
        check({tag, " result"}, bus.result, exp);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready drop"}, 64'(bus.ready), 64'd0);
        check({tag, " result hold"}, bus.result, exp);
        $display("[TB] %s s=%0d %h / %h -> %h lat=%0d", tag, s, a, b, exp, lat);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        int          seen;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1 = 32'd0;
        bus.opdata2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset result", bus.result, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle ready", 64'(bus.ready), 64'd0);

        run(32'd100, 32'd7, 1'b0, 1'b0, "udiv 100/7");
        run(32'hFFFFFFF9, 32'h2, 1'b1, 1'b0, "sdiv -7/2");
        run(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, "sdiv min/-1");
        run(32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, "udiv max/16");
        run(32'h80000000, 32'h3, 1'b1, 1'b0, "sdiv min/3");
        run(32'd12345, 32'd0, 1'b0, 1'b0, "udiv by zero");
        run(32'hFFFFFF00, 32'd0, 1'b1, 1'b0, "sdiv by zero");
        run(32'hDEADBEEF, 32'h00001234, 1'b0, 1'b1, "scrambled udiv");
        run(32'h9ABCDEF0, 32'hFFFFFFF3, 1'b1, 1'b1, "scrambled sdiv");

        // annul wins over start in IDLE: nothing may be latched
        bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.start = 1'b1; bus.annul = 1'b1;
        seen = 0;
        for (int n = 0; n < 36; n++) begin
            @(posedge clk); #1;
            if (bus.ready) seen++;
        end
        check("annul in idle", 64'(seen), 64'd0);
        bus.start = 1'b0; bus.annul = 1'b0;
        @(posedge clk); #1;

        // annul at cycle 10 of ON, then restart next cycle
        bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (bus.ready) seen++;
        end
        bus.annul = 1'b1;
        @(posedge clk); #1;
        check("annul no ready", 64'(seen + int'(bus.ready)), 64'd0);
        check("annul result kept", bus.result, model(32'h9ABCDEF0, 32'hFFFFFFF3, 1'b1));
        bus.annul = 1'b0;
        run(32'd9, 32'd3, 1'b0, 1'b0, "after annul 9/3");

        // reset at cycle 20 of ON discards the divide
        bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("mid-on rst ready", 64'(bus.ready), 64'd0);
        check("mid-on rst result", bus.result, 64'h0);
        rst = 1'b0;
        run(32'd1000, 32'd33, 1'b0, 1'b0, "after rst 1000/33");

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 255));
                2: rb = -32'($urandom_range(1, 255));
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = 32'd0;
            endcase
            rs = 1'($urandom_range(0, 1));
            run(ra, rb, rs, (i % 3) == 0, $sformatf("random %0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 clk  input  1  rising-edge clock; all state and outputs are registered on it.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-004 opdata1  input  32  dividend; sampled with start.
REQ-005 opdata2  input  32  divisor; sampled with start.
REQ-006 start  input  1  request; held high by the ALU until ready is seen.
REQ-007 annul  input  1  abort request from exception flush.
REQ-008 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 ready  output  1  result valid.

Function
REQ-010 The FSM SHALL have four states: IDLE, BYZERO, ON and END.
REQ-011 IDLE, start=1, annul=0: latch signed_div, opdata1 and opdata2; go to BYZERO if the divisor is 0, else go to ON.
REQ-012 IDLE, start=0 or annul=1: stay in IDLE; ready=0.
REQ-013 Once latched, the operands SHALL be used exclusively; changes on opdata1, opdata2 and signed_div during BYZERO or ON SHALL have no effect.
REQ-014 Signed mode SHALL divide the absolute values (two's-complement negate when the MSB is 1; 0x80000000 stays 0x80000000 as an unsigned magnitude). Unsigned mode SHALL use the operands as-is.
REQ-015 ON SHALL run one restoring shift-subtract step per cycle using a 6-bit iteration counter; exactly 32 cycles in ON, then go to END.
REQ-016 Each step: shift {partial remainder, dividend} left by 1; trial-subtract the divisor magnitude from the upper 33 bits; if there is no borrow, keep the difference and set quotient bit 1, else keep the shifted value and set quotient bit 0.
REQ-017 Signed fixup on entering END: negate the quotient if the dividend and divisor signs differ; give the remainder the sign of the dividend. Results wrap at 32 bits, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
REQ-018 BYZERO SHALL go to END after one cycle with result = 64'h0.
REQ-019 END: ready=1 and result is driven with the final value; both held while start=1.
REQ-020 END, start=0: go to IDLE; ready=0 in the next cycle; result holds its last value until the next latch.
REQ-021 Latency: with start sampled at edge 0, ready=1 after edge 33 for a normal divide and after edge 2 for a zero divisor.
REQ-022 ON or BYZERO, annul=1: go to IDLE at the next edge; ready stays 0; result is unchanged.
REQ-023 ON, start=0: treated as annul.
REQ-024 annul has priority over start in every state.
REQ-025 A new start in IDLE SHALL be accepted on the cycle immediately after an annul or after END exits.
REQ-026 ready SHALL never be 1 outside END.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, ready=0, result=64'h0 and counter=0, overriding start and annul.
REQ-028 rst=1 in any state, including mid-ON, SHALL discard the divide in progress.
REQ-029 After rst falls, the first start SHALL be accepted at the next edge.

Verification
REQ-030 Unsigned 100/7, start held -> ready after edge 33; result = {32'd2, 32'd14}; drop start -> ready=0 one cycle later.
REQ-031 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result = {0xFFFFFFFF, 0xFFFFFFFD}; signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF/0x00000010 -> {0x0000000F, 0x0FFFFFFF}.
REQ-032 Divisor 0, either mode -> ready after edge 2; result = 64'h0.
REQ-033 annul pulse at cycle 10 of ON -> IDLE next edge; ready never asserts; a new start for 9/3 next cycle -> {0, 3} after 33 edges.
REQ-034 Change opdata1 and opdata2 every cycle during ON -> result matches the operands latched at start.
REQ-035 rst asserted at cycle 20 of ON -> ready=0 and result=0 after that edge; next divide completes normally.
